// File: rtl/gmux_ctrl_pkg.sv
// Shared types and defaults for the global-mux select controller.
package gmux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'b00,
    ST_ARM_ON  = 2'b01,
    ST_ON      = 2'b10,
    ST_ARM_OFF = 2'b11
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF   = 32'd2;
  localparam int unsigned SETTLE_CYCLES_DEF = 32'd4;
  localparam int unsigned CNT_W_DEF         = 32'd4;

  // A transition state lasts settle cycles, so the counter starts one below.
  function automatic int unsigned settle_load(input int unsigned settle);
    if (settle == 32'd0) begin
      return 32'd0;
    end else begin
      return settle - 32'd1;
    end
  endfunction

endpackage

// File: rtl/gmux_gate_ctrl_if.sv
// Request/acknowledge and select bundle between a requester and the controller.
interface gmux_gate_ctrl_if;

  logic EN_REQ;
  logic IS0;
  logic EN_ACK;
  logic BUSY;

  modport master (output EN_REQ, input IS0, input EN_ACK, input BUSY);
  modport slave  (input EN_REQ, output IS0, output EN_ACK, output BUSY);

endinterface

// File: rtl/gmux_req_sync.sv
// Multi-flop synchronizer bringing the enable request into the QCK domain.
module gmux_req_sync #(
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic QCK,
  input  logic QRT,
  input  logic en_req_i,
  output logic req_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], en_req_i};
    end
  end

  assign req_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gmux_gate_ctrl.sv
// Glitch-free select controller for a global clock mux: synchronized request,
// settle-timed arm states, and registered IS0/EN_ACK/BUSY.
module gmux_gate_ctrl
  import gmux_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input logic             QCK,
  input logic             QRT,
  gmux_gate_ctrl_if.slave bus_if
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(settle_load(SETTLE_CYCLES));

  logic             req_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is0_q, is0_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  gmux_req_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .QCK      (QCK),
    .QRT      (QRT),
    .en_req_i (bus_if.EN_REQ),
    .req_s_o  (req_s)
  );

  // Arm states always run to completion; req_s is only looked at in OFF and ON.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (req_s) begin
          state_d = ST_ARM_ON;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_ARM_ON: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ON: begin
        if (!req_s) begin
          state_d = ST_ARM_OFF;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_ARM_OFF: begin
        if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they are registered alongside it.
  always_comb begin
    is0_d  = (state_d == ST_ON);
    ack_d  = (state_d == ST_ON) || (state_d == ST_ARM_OFF);
    busy_d = (state_d == ST_ARM_ON) || (state_d == ST_ARM_OFF);
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      is0_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is0_q   <= is0_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_if.IS0    = is0_q;
  assign bus_if.EN_ACK = ack_q;
  assign bus_if.BUSY   = busy_q;

endmodule
